dmem_port_arbiter: RTL and testbench
====================================

# dmem_port_arbiter

Shares the single data-memory port between the execute-phase load/store unit and a secondary requester (program loader / debug DMA). Execute has priority. A starvation counter and a two-state FSM guarantee the loader forward progress by stalling execute for a bounded burst. Fixed-latency read data is returned to the requester that issued the read, using a tag pipeline matched to the memory load latency.

## Interface
Parameters:
- ADDR_W, 20, word-address width (byte offset already stripped by requesters)
- LOAD_LATENCY, 1, cycles from registered command edge to valid mem_rdata
- STARVE_MAX, 8, consecutive denied loader cycles before forced grant (≥1)
- BURST_MAX, 4, maximum loader beats per forced grant (≥1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- ex_req  in  1  execute access request, held while ex_stall=1
- ex_we  in  8  byte write enables; 0 = read
- ex_addr  in  ADDR_W  word address
- ex_wdata  in  64  store data, pre-shifted to byte lanes
- ex_stall  out  1  execute request not accepted this cycle (combinational)
- ex_rvalid  out  1  read data for execute valid this cycle
- ex_rdata  out  64  read data for execute
- ld_req, ld_we, ld_addr, ld_wdata  in  1/8/ADDR_W/64  loader request, same meaning
- ld_gnt  out  1  loader request accepted this cycle (combinational)
- ld_rvalid, ld_rdata  out  1/64  loader read return
- mem_en  out  1  registered command valid
- mem_we  out  8  registered byte enables
- mem_addr  out  ADDR_W  registered word address
- mem_wdata  out  64  registered store data
- mem_rdata  in  64  memory read data

## Operation
- FSM states: NORM, FORCE. Reset state is NORM.
- NORM:
  - If ex_req=1, execute wins.
  - Otherwise, if ld_req=1, the loader wins.
  - ex_stall=0 in NORM.
- Starvation counter (width clog2(STARVE_MAX+1)):
  - Increments on each cycle with ld_req=1 and ld_gnt=0.
  - Clears on any cycle with ld_gnt=1, or with ld_req=0.
  - Saturates at STARVE_MAX.
- NORM→FORCE: the counter equals STARVE_MAX at a clock edge. Forcing applies from the next cycle.
- FORCE:
  - The loader wins whenever ld_req=1.
  - ex_stall = ex_req.
  - The beat counter increments per loader grant.
- FORCE→NORM:
  - After BURST_MAX loader grants, or
  - on the first FORCE cycle with ld_req=0; execute may be granted in that same cycle, and ex_stall=0.
- On FORCE exit, the beat counter clears.
- Winner's command is registered into mem_*; mem_en=1. A cycle with no winner yields mem_en=0 and mem_we=0.
- Read tag pipeline:
  - LOAD_LATENCY+1 entries of {valid, owner}.
  - An entry is pushed with valid=1 for a granted request with we=0; a write or idle cycle pushes valid=0.
- Read return:
  - Entry at depth LOAD_LATENCY drives ex_rvalid/ld_rvalid by owner.
  - mem_rdata is passed unmodified to both *_rdata; only rvalid is steered.
- Ordering: single in-order port, so no read/write hazards. A loader write followed by an execute read of the same address returns the new data.

## Timing
- Reset values:
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - All tag entries invalid, so ex_rvalid=0 and ld_rvalid=0.
  - State NORM; both counters 0.
  - ex_stall=0 and ld_gnt=0 while rst=1.
- Grant to command: a request accepted in cycle t appears on mem_* in cycle t+1.
- Read latency: read data is returned in cycle t+1+LOAD_LATENCY (default t+2).
- Throughput: one access per cycle. There are no bubbles between grants, including across FORCE entry and exit.
- Simultaneous ex_req and ld_req:
  - In NORM, execute wins.
  - In FORCE, the loader wins.
- Reset asserted mid-operation:
  - In-flight tags are discarded; no rvalid is produced for reads issued before reset.
  - The FSM returns to NORM immediately (asynchronous).
- STARVE_MAX=1: the loader is forced after a single denied cycle.
- BURST_MAX=1: FORCE lasts exactly one loader grant.

## Test plan
- Reset: assert rst mid-stream with 2 reads in flight → all mem_* and rvalids 0; no rvalid after release.
- Idle-slot loader:
  - Stimulus: ex_req=0, ld read at addr 0x00010 in cycle 5.
  - Response: ld_gnt=1 in cycle 5; mem_en=1 with mem_addr=0x00010 in cycle 6; ld_rvalid=1 in cycle 7 with mem_rdata.
- Contention:
  - Stimulus: ex_req and ld_req held 1 continuously, STARVE_MAX=8, BURST_MAX=4.
  - Response: execute granted 8 cycles, then ex_stall=1 with 4 loader grants, then repeats (8/4 pattern). No mem_en gap.
- Early FORCE exit: ld_req drops after 2 forced beats → FSM returns to NORM that cycle, ex_stall=0, execute granted.
- Interleaved reads:
  - Stimulus: alternating execute read of 0x00100 and loader read of 0x00200 over 6 cycles.
  - Response: each rvalid is steered to its issuer in order, 2 cycles after grant; never both rvalids in the same cycle.
- Write then read:
  - Stimulus: loader writes 0xDEADBEEF_00000000 with we=0xF0 to 0x00040, then execute reads 0x00040.
  - Response: mem_we=0xF0 on the write cycle; ex_rdata reflects memory contents; no rvalid for the write.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single data-memory port between execute (priority) and the loader.
// States: NORM = execute has priority | FORCE = loader owns the port for up to BURST_MAX beats.
module dmem_port_arbiter #(
  parameter int ADDR_W       = 20,
  parameter int LOAD_LATENCY = 1,
  parameter int STARVE_MAX   = 8,
  parameter int BURST_MAX    = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ex_req,
  input  logic [7:0]        i_ex_we,
  input  logic [ADDR_W-1:0] i_ex_addr,
  input  logic [63:0]       i_ex_wdata,
  output logic              o_ex_stall,
  output logic              o_ex_rvalid,
  output logic [63:0]       o_ex_rdata,
  input  logic              i_ld_req,
  input  logic [7:0]        i_ld_we,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [63:0]       i_ld_wdata,
  output logic              o_ld_gnt,
  output logic              o_ld_rvalid,
  output logic [63:0]       o_ld_rdata,
  output logic              o_mem_en,
  output logic [7:0]        o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [63:0]       o_mem_wdata,
  input  logic [63:0]       i_mem_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int BW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [BW-1:0] BEAT_LAST  = BW'(BURST_MAX - 1);

  typedef enum logic {
    ST_NORM  = 1'b0,
    ST_FORCE = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [SW-1:0]         r_starve;
  logic [SW-1:0]         w_starve_nxt;
  logic [BW-1:0]         r_beat;
  logic [BW-1:0]         w_beat_nxt;
  logic                  w_ex_win;
  logic                  w_ld_win;
  logic                  w_push_vld;
  logic [LOAD_LATENCY:0] r_tag_vld;
  logic [LOAD_LATENCY:0] r_tag_ld;

  always_comb begin
    w_state_nxt  = r_state;
    w_beat_nxt   = r_beat;
    w_starve_nxt = '0;
    w_ex_win     = 1'b0;
    w_ld_win     = 1'b0;
    o_ex_stall   = 1'b0;
    if (!i_rst) begin
      case (r_state)
        ST_NORM: begin
          w_ex_win = i_ex_req;
          w_ld_win = !i_ex_req && i_ld_req;
        end
        ST_FORCE: begin
          if (i_ld_req) begin
            w_ld_win   = 1'b1;
            o_ex_stall = i_ex_req;
            if (r_beat == BEAT_LAST) begin
              w_state_nxt = ST_NORM;
              w_beat_nxt  = '0;
            end else begin
              w_beat_nxt = r_beat + BW'(1);
            end
          end else begin
            // Loader went idle mid-burst: hand the slot straight back to execute.
            w_ex_win    = i_ex_req;
            w_state_nxt = ST_NORM;
            w_beat_nxt  = '0;
          end
        end
        default: w_state_nxt = ST_NORM;
      endcase
    end
    if (i_ld_req && !w_ld_win)
      w_starve_nxt = (r_starve == STARVE_LIM) ? r_starve : r_starve + SW'(1);
    if (r_state == ST_NORM && w_starve_nxt == STARVE_LIM)
      w_state_nxt = ST_FORCE;
  end

  assign o_ld_gnt   = w_ld_win;
  assign w_push_vld = (w_ex_win && i_ex_we == 8'h00) || (w_ld_win && i_ld_we == 8'h00);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= ST_NORM;
      r_starve <= '0;
      r_beat   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
      r_beat   <= w_beat_nxt;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_mem_en    <= 1'b0;
      o_mem_we    <= 8'h00;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
    end else if (w_ex_win) begin
      o_mem_en    <= 1'b1;
      o_mem_we    <= i_ex_we;
      o_mem_addr  <= i_ex_addr;
      o_mem_wdata <= i_ex_wdata;
    end else if (w_ld_win) begin
      o_mem_en    <= 1'b1;
      o_mem_we    <= i_ld_we;
      o_mem_addr  <= i_ld_addr;
      o_mem_wdata <= i_ld_wdata;
    end else begin
      o_mem_en <= 1'b0;
      o_mem_we <= 8'h00;
    end
  end

  // Owner tag travels alongside the command so returns are steered to the issuer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tag_vld <= '0;
      r_tag_ld  <= '0;
    end else begin
      r_tag_vld[0] <= w_push_vld;
      r_tag_ld[0]  <= w_ld_win;
      for (int i = 1; i <= LOAD_LATENCY; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_ld[i]  <= r_tag_ld[i-1];
      end
    end
  end

  assign o_ex_rvalid = r_tag_vld[LOAD_LATENCY] && !r_tag_ld[LOAD_LATENCY];
  assign o_ld_rvalid = r_tag_vld[LOAD_LATENCY] && r_tag_ld[LOAD_LATENCY];
  assign o_ex_rdata  = i_mem_rdata;
  assign o_ld_rdata  = i_mem_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios plus randomized traffic checked
// against a cycle-level reference of grant rules, reference memory and read returns.
module tb_dmem_port_arbiter;
  localparam int AW = 20;
  localparam int LL = 1;
  localparam int SM = 8;
  localparam int BM = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ex_req = 1'b0, ld_req = 1'b0;
  logic [7:0]    ex_we = '0, ld_we = '0;
  logic [AW-1:0] ex_addr = '0, ld_addr = '0;
  logic [63:0]   ex_wdata = '0, ld_wdata = '0;
  logic          ex_stall, ex_rvalid, ld_gnt, ld_rvalid, mem_en;
  logic [63:0]   ex_rdata, ld_rdata, mem_wdata;
  logic [63:0]   mem_rdata = '0;
  logic [7:0]    mem_we;
  logic [AW-1:0] mem_addr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.ADDR_W(AW), .LOAD_LATENCY(LL), .STARVE_MAX(SM), .BURST_MAX(BM)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ex_req(ex_req), .i_ex_we(ex_we), .i_ex_addr(ex_addr), .i_ex_wdata(ex_wdata),
    .o_ex_stall(ex_stall), .o_ex_rvalid(ex_rvalid), .o_ex_rdata(ex_rdata),
    .i_ld_req(ld_req), .i_ld_we(ld_we), .i_ld_addr(ld_addr), .i_ld_wdata(ld_wdata),
    .o_ld_gnt(ld_gnt), .o_ld_rvalid(ld_rvalid), .o_ld_rdata(ld_rdata),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata)
  );

  function automatic logic [63:0] init_val(input logic [AW-1:0] a);
    return {12'hA5C, a, 12'h3B1, a};
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                        input logic [7:0] we);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++)
      if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Memory device: one-cycle registered read, byte-masked write.
  logic [63:0] env_mem [int];
  logic [63:0] env_cur;
  always @(posedge clk) begin
    if (mem_en) begin
      env_cur = env_mem.exists(int'(mem_addr)) ? env_mem[int'(mem_addr)] : init_val(mem_addr);
      if (mem_we != 8'h00) env_mem[int'(mem_addr)] = merge(env_cur, mem_wdata, mem_we);
      else mem_rdata <= env_cur;
    end
  end

  // Reference model state
  bit            m_forced;
  int            m_denied, m_beats, cyc;
  logic [63:0]   ref_mem [int];
  bit            rv_ex [int];
  bit            rv_ld [int];
  logic [63:0]   rv_data [int];
  bit            n_en;
  logic [7:0]    n_we;
  logic [AW-1:0] n_addr;
  logic [63:0]   n_wdata;
  bit            e_stall, e_ld_gnt, e_en, e_ex_rv, e_ld_rv;
  logic [7:0]    e_we;
  logic [AW-1:0] e_addr;
  logic [63:0]   e_wdata, e_rdata;

  task automatic model_reset();
    m_forced = 0; m_denied = 0; m_beats = 0;
    n_en = 0; n_we = '0; n_addr = '0; n_wdata = '0;
    rv_ex.delete(); rv_ld.delete(); rv_data.delete();
  endtask

  // Called once per cycle with inputs stable; yields expectations for this cycle.
  task automatic model_cycle();
    bit exg, ldg, wf;
    int k;
    logic [63:0] old;
    e_en = n_en; e_we = n_we; e_addr = n_addr; e_wdata = n_wdata;
    e_ex_rv = rv_ex.exists(cyc) ? rv_ex[cyc] : 1'b0;
    e_ld_rv = rv_ld.exists(cyc) ? rv_ld[cyc] : 1'b0;
    e_rdata = rv_data.exists(cyc) ? rv_data[cyc] : 64'h0;
    wf = m_forced;
    if (!m_forced) begin
      exg = ex_req; ldg = !ex_req && ld_req; e_stall = 0;
    end else if (ld_req) begin
      exg = 0; ldg = 1; e_stall = ex_req;
    end else begin
      exg = ex_req; ldg = 0; e_stall = 0;
    end
    e_ld_gnt = ldg;
    n_en = exg || ldg;
    n_we = exg ? ex_we : (ldg ? ld_we : 8'h00);
    if (exg) begin n_addr = ex_addr; n_wdata = ex_wdata; end
    else if (ldg) begin n_addr = ld_addr; n_wdata = ld_wdata; end
    if (n_en) begin
      k = int'(n_addr);
      old = ref_mem.exists(k) ? ref_mem[k] : init_val(n_addr);
      if (n_we == 8'h00) begin
        rv_ex[cyc+1+LL] = exg; rv_ld[cyc+1+LL] = ldg; rv_data[cyc+1+LL] = old;
      end else ref_mem[k] = merge(old, n_wdata, n_we);
    end
    if (wf) begin
      if (ldg) begin
        m_beats++;
        if (m_beats == BM) begin m_forced = 0; m_beats = 0; end
      end else begin
        m_forced = 0; m_beats = 0;
      end
    end
    m_denied = (ld_req && !ldg) ? ((m_denied < SM) ? m_denied + 1 : SM) : 0;
    if (!wf && m_denied == SM) m_forced = 1;
    cyc++;
  endtask

  task automatic drive(input bit er, input logic [7:0] ew, input logic [AW-1:0] ea,
                       input logic [63:0] ed, input bit lr, input logic [7:0] lw,
                       input logic [AW-1:0] la, input logic [63:0] lwd);
    ex_req = er; ex_we = ew; ex_addr = ea; ex_wdata = ed;
    ld_req = lr; ld_we = lw; ld_addr = la; ld_wdata = lwd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk); model_cycle();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    drive(1, 0, 20'h7, 0, 1, 0, 20'h9, 0);
    @(negedge clk);
    n_tests++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin n_fail++;
      $display("FAIL rst_mem: got en=%0b we=%0h addr=%0h wd=%0h want all 0", mem_en, mem_we, mem_addr, mem_wdata); end
    n_tests++; if ({ex_rvalid, ld_rvalid} !== 2'b00) begin n_fail++;
      $display("FAIL rst_rvalid: got %0b%0b want 00", ex_rvalid, ld_rvalid); end
    n_tests++; if ({ex_stall, ld_gnt} !== 2'b00) begin n_fail++;
      $display("FAIL rst_gnt: got stall=%0b gnt=%0b want 0 0", ex_stall, ld_gnt); end
    rst = 0; model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(1, 0, 20'h3, 0, 0, 0, 0, 0);
    @(negedge clk); model_cycle(); @(posedge clk); #1;
    drive(0, 0, 0, 0, 1, 0, 20'h5, 0);
    @(negedge clk); model_cycle(); @(posedge clk); #1;
    rst = 1;
    #1;
    n_tests++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin n_fail++;
      $display("FAIL midrst_mem: got en=%0b we=%0h addr=%0h want all 0", mem_en, mem_we, mem_addr); end
    n_tests++; if ({ex_rvalid, ld_rvalid} !== 2'b00) begin n_fail++;
      $display("FAIL midrst_rvalid: got %0b%0b want 00", ex_rvalid, ld_rvalid); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst = 0; model_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); model_cycle();
      n_tests++; if ({ex_rvalid, ld_rvalid} !== 2'b00) begin n_fail++;
        $display("FAIL postrst_rvalid c%0d: got %0b%0b want 00", i, ex_rvalid, ld_rvalid); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_idle_loader();
    idle(3);
    for (int i = 0; i < 9; i++) begin
      if (i == 5) drive(0, 0, 0, 0, 1, 0, 20'h00010, 0);
      else drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk); model_cycle();
      if (i == 5) begin
        n_tests++; if (ld_gnt !== 1'b1) begin n_fail++;
          $display("FAIL idle_ld_gnt: got %0b want 1", ld_gnt); end
      end
      if (i == 6) begin
        n_tests++; if (mem_en !== 1'b1 || mem_addr !== 20'h00010 || mem_we !== 8'h00) begin n_fail++;
          $display("FAIL idle_ld_cmd: got en=%0b addr=%0h we=%0h want 1 10 0", mem_en, mem_addr, mem_we); end
      end
      if (i == 7) begin
        n_tests++; if (ld_rvalid !== 1'b1 || ex_rvalid !== 1'b0) begin n_fail++;
          $display("FAIL idle_ld_rvalid: got ld=%0b ex=%0b want 1 0", ld_rvalid, ex_rvalid); end
        n_tests++; if (ld_rdata !== init_val(20'h00010)) begin n_fail++;
          $display("FAIL idle_ld_rdata: got %0h want %0h", ld_rdata, init_val(20'h00010)); end
      end
      if (i == 8) begin
        n_tests++; if (ld_rvalid !== 1'b0) begin n_fail++;
          $display("FAIL idle_ld_rvalid_end: got %0b want 0", ld_rvalid); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_contention();
    int exn, ldn;
    bit want_ld;
    exn = 0; ldn = 0;
    idle(3);
    for (int i = 0; i < 24; i++) begin
      drive(1, 0, 20'h00100 + AW'(exn), 0, 1, 0, 20'h00200 + AW'(ldn), 0);
      @(negedge clk); model_cycle();
      want_ld = (i % 12) >= 8;
      n_tests++; if (ex_stall !== want_ld || ld_gnt !== want_ld) begin n_fail++;
        $display("FAIL cont_pattern c%0d: got stall=%0b gnt=%0b want %0b %0b", i, ex_stall, ld_gnt, want_ld, want_ld); end
      if (i > 0) begin
        n_tests++; if (mem_en !== 1'b1 || mem_addr !== e_addr) begin n_fail++;
          $display("FAIL cont_cmd c%0d: got en=%0b addr=%0h want 1 %0h", i, mem_en, mem_addr, e_addr); end
      end
      n_tests++; if (ex_rvalid !== e_ex_rv || ld_rvalid !== e_ld_rv) begin n_fail++;
        $display("FAIL cont_rvalid c%0d: got ex=%0b ld=%0b want %0b %0b", i, ex_rvalid, ld_rvalid, e_ex_rv, e_ld_rv); end
      if (!want_ld) exn++; else ldn++;
      @(posedge clk); #1;
    end
    idle(3);
  endtask

  task automatic test_early_exit();
    bit ws, wg;
    idle(3);
    for (int i = 0; i < 12; i++) begin
      drive(1, 0, 20'h00300, 0, (i != 10), 0, 20'h00380, 0);
      @(negedge clk); model_cycle();
      ws = (i == 8 || i == 9);
      wg = ws;
      n_tests++; if (ex_stall !== ws || ld_gnt !== wg) begin n_fail++;
        $display("FAIL early_grant c%0d: got stall=%0b gnt=%0b want %0b %0b", i, ex_stall, ld_gnt, ws, wg); end
      if (i == 11) begin
        n_tests++; if (mem_en !== 1'b1 || mem_addr !== 20'h00300) begin n_fail++;
          $display("FAIL early_ex_cmd: got en=%0b addr=%0h want 1 300", mem_en, mem_addr); end
      end
      @(posedge clk); #1;
    end
    idle(3);
  endtask

  task automatic test_interleaved();
    bit wx, wl;
    idle(3);
    for (int j = 0; j < 9; j++) begin
      if (j < 6 && j % 2 == 0) drive(1, 0, 20'h00100, 0, 0, 0, 0, 0);
      else if (j < 6) drive(0, 0, 0, 0, 1, 0, 20'h00200, 0);
      else drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk); model_cycle();
      wx = (j >= 2 && j <= 7 && j % 2 == 0);
      wl = (j >= 2 && j <= 7 && j % 2 == 1);
      n_tests++; if (ex_rvalid !== wx || ld_rvalid !== wl) begin n_fail++;
        $display("FAIL inter_rvalid c%0d: got ex=%0b ld=%0b want %0b %0b", j, ex_rvalid, ld_rvalid, wx, wl); end
      if (wx) begin
        n_tests++; if (ex_rdata !== init_val(20'h00100)) begin n_fail++;
          $display("FAIL inter_ex_rdata c%0d: got %0h want %0h", j, ex_rdata, init_val(20'h00100)); end
      end
      if (wl) begin
        n_tests++; if (ld_rdata !== init_val(20'h00200)) begin n_fail++;
          $display("FAIL inter_ld_rdata c%0d: got %0h want %0h", j, ld_rdata, init_val(20'h00200)); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_write_read();
    logic [63:0] iv, exp;
    iv = init_val(20'h00040);
    exp = {32'hDEADBEEF, iv[31:0]};
    idle(3);
    for (int i = 0; i < 5; i++) begin
      if (i == 0) drive(0, 0, 0, 0, 1, 8'hF0, 20'h00040, 64'hDEADBEEF_00000000);
      else if (i == 1) drive(1, 0, 20'h00040, 0, 0, 0, 0, 0);
      else drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk); model_cycle();
      if (i == 1) begin
        n_tests++; if (mem_en !== 1'b1 || mem_we !== 8'hF0 || mem_addr !== 20'h00040 ||
                       mem_wdata !== 64'hDEADBEEF_00000000) begin n_fail++;
          $display("FAIL wr_cmd: got en=%0b we=%0h addr=%0h wd=%0h want 1 f0 40 deadbeef00000000", mem_en, mem_we, mem_addr, mem_wdata); end
      end
      if (i == 2) begin
        n_tests++; if (ex_rvalid !== 1'b0 || ld_rvalid !== 1'b0) begin n_fail++;
          $display("FAIL wr_no_rvalid: got ex=%0b ld=%0b want 0 0", ex_rvalid, ld_rvalid); end
      end
      if (i == 3) begin
        n_tests++; if (ex_rvalid !== 1'b1 || ex_rdata !== exp) begin n_fail++;
          $display("FAIL rd_after_wr: got v=%0b d=%0h want 1 %0h", ex_rvalid, ex_rdata, exp); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    bit ex_pend, ld_pend;
    ex_pend = 0; ld_pend = 0;
    idle(3);
    for (int i = 0; i < 400; i++) begin
      if (!ex_pend) begin
        ex_req = ($urandom_range(0, 9) < 7);
        ex_we = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        ex_addr = 20'h01000 + AW'($urandom_range(0, 15));
        ex_wdata = {$urandom, $urandom};
      end
      if (!ld_pend) begin
        ld_req = ($urandom_range(0, 9) < 5);
        ld_we = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        ld_addr = 20'h01000 + AW'($urandom_range(0, 15));
        ld_wdata = {$urandom, $urandom};
      end
      @(negedge clk); model_cycle();
      n_tests++; if (ex_stall !== e_stall || ld_gnt !== e_ld_gnt) begin n_fail++;
        $display("FAIL rnd_grant c%0d: got stall=%0b gnt=%0b want %0b %0b", i, ex_stall, ld_gnt, e_stall, e_ld_gnt); end
      n_tests++; if (mem_en !== e_en || mem_we !== e_we) begin n_fail++;
        $display("FAIL rnd_en c%0d: got en=%0b we=%0h want %0b %0h", i, mem_en, mem_we, e_en, e_we); end
      if (e_en) begin
        n_tests++; if (mem_addr !== e_addr || mem_wdata !== e_wdata) begin n_fail++;
          $display("FAIL rnd_cmd c%0d: got addr=%0h wd=%0h want %0h %0h", i, mem_addr, mem_wdata, e_addr, e_wdata); end
      end
      n_tests++; if (ex_rvalid !== e_ex_rv || ld_rvalid !== e_ld_rv) begin n_fail++;
        $display("FAIL rnd_rvalid c%0d: got ex=%0b ld=%0b want %0b %0b", i, ex_rvalid, ld_rvalid, e_ex_rv, e_ld_rv); end
      if (e_ex_rv) begin
        n_tests++; if (ex_rdata !== e_rdata) begin n_fail++;
          $display("FAIL rnd_ex_rdata c%0d: got %0h want %0h", i, ex_rdata, e_rdata); end
      end
      if (e_ld_rv) begin
        n_tests++; if (ld_rdata !== e_rdata) begin n_fail++;
          $display("FAIL rnd_ld_rdata c%0d: got %0h want %0h", i, ld_rdata, e_rdata); end
      end
      ex_pend = ex_req && e_stall;
      ld_pend = ld_req && !e_ld_gnt;
      @(posedge clk); #1;
    end
    idle(3);
  endtask

  initial begin
    cyc = 0;
    model_reset();
    test_reset();
    test_idle_loader();
    test_contention();
    test_early_exit();
    test_interleaved();
    test_write_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
